// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one backing memory port between instruction and data requesters.
// Requests are registered towards memory; single-beat responses route back combinationally.
package mem_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

endpackage

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned max_burst = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  input  mem_out_type mem_out,
  output mem_in_type  mem_in
);

  localparam logic [3:0] CNT_MAX = 4'(max_burst);
  localparam logic       PORT_I  = 1'b0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg;
  mem_in_type  req_reg;
  logic        owner_reg;
  logic        last_reg;
  logic [3:0]  cnt_reg;

  logic        grant_next;
  logic [3:0]  cnt_next;
  mem_in_type  port_req [2];
  mem_out_type port_rsp [2];

  assign port_req[0] = imem_in;
  assign port_req[1] = dmem_in;
  assign imem_out    = port_rsp[0];
  assign dmem_out    = port_rsp[1];
  assign mem_in      = req_reg;

  // Port index 1 is the data side, so a lone data request selects it directly.
  always_comb begin
    grant_next = dmem_in.mem_valid;
    if (imem_in.mem_valid && dmem_in.mem_valid) begin
      grant_next = (cnt_reg == CNT_MAX) ? ~last_reg : last_reg;
    end
    cnt_next = (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      owner_reg <= PORT_I;
      last_reg  <= PORT_I;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (imem_in.mem_valid || dmem_in.mem_valid) begin
            req_reg           <= port_req[grant_next];
            req_reg.mem_valid <= 1'b1;
            owner_reg         <= grant_next;
            state_reg         <= BUSY;
          end
        end
        BUSY: begin
          if (mem_out.mem_ready) begin
            req_reg.mem_valid <= 1'b0;
            state_reg         <= IDLE;
            if (owner_reg == last_reg) begin
              cnt_reg <= cnt_next;
            end else begin
              cnt_reg  <= 4'd1;
              last_reg <= owner_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Only the current owner sees the memory response, and only while a transaction is open.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic hit;
      assign hit          = (state_reg == BUSY) && (owner_reg == 1'(gi)) && mem_out.mem_ready;
      assign port_rsp[gi] = hit ? mem_out : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, field latching, response routing and reset.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_out_type mem_out;
  mem_in_type  mem_in;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.max_burst(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_out  (mem_out),
    .mem_in   (mem_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(mem_in.mem_valid), 32'd0);
    chk("rst_addr", mem_in.mem_addr, 32'd0);
    chk("rst_i_ready", 32'(imem_out.mem_ready), 32'd0);
    chk("rst_d_ready", 32'(dmem_out.mem_ready), 32'd0);
    chk("rst_i_rdata", imem_out.mem_rdata, 32'd0);
    rst = 1'b0;
    $display("reset applied and released at %0t", $time);
  endtask

  // Acts as the memory: waits for the grant, holds ready off for lat-1 BUSY cycles, then completes.
  task automatic serve(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                       input bit exp_fence, input int exp_wait, input int lat,
                       input logic [31:0] rd, input bit keep, input bit scramble);
    int n = 0;
    while (!mem_in.mem_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    chk({tag, "_valid"}, 32'(mem_in.mem_valid), 32'd1);
    chk({tag, "_addr"}, mem_in.mem_addr, exp_addr);
    chk({tag, "_instr"}, 32'(mem_in.mem_instr), 32'(!exp_d));
    chk({tag, "_fence"}, 32'(mem_in.mem_fence), 32'(exp_fence));
    for (int i = 1; i < lat; i++) begin
      if (scramble) begin
        if (exp_d) dmem_in.mem_addr = exp_addr + 32'd4;
        else       imem_in.mem_addr = exp_addr + 32'd4;
      end
      @(negedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(mem_in.mem_valid), 32'd1);
      chk({tag, "_hold_addr"}, mem_in.mem_addr, exp_addr);
      chk({tag, "_early_ready"}, 32'(imem_out.mem_ready | dmem_out.mem_ready), 32'd0);
    end
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = rd;
    #1;
    if (exp_d) begin
      chk({tag, "_d_ready"}, 32'(dmem_out.mem_ready), 32'd1);
      chk({tag, "_d_rdata"}, dmem_out.mem_rdata, rd);
      chk({tag, "_i_ready"}, 32'(imem_out.mem_ready), 32'd0);
      chk({tag, "_i_rdata"}, imem_out.mem_rdata, 32'd0);
      if (!keep) dmem_in.mem_valid = 1'b0;
    end else begin
      chk({tag, "_i_ready"}, 32'(imem_out.mem_ready), 32'd1);
      chk({tag, "_i_rdata"}, imem_out.mem_rdata, rd);
      chk({tag, "_d_ready"}, 32'(dmem_out.mem_ready), 32'd0);
      chk({tag, "_d_rdata"}, dmem_out.mem_rdata, 32'd0);
      if (!keep) imem_in.mem_valid = 1'b0;
    end
    @(negedge clk);
    mem_out = '0;
    #1;
    chk({tag, "_idle_valid"}, 32'(mem_in.mem_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(imem_out.mem_ready | dmem_out.mem_ready), 32'd0);
    $display("txn %s owner=%s addr=%h rdata=%h wait=%0d", tag, exp_d ? "D" : "I", exp_addr, rd, n);
  endtask

  logic [31:0] iaddr;
  bit          order [8];

  initial begin
    // Single instruction read, 3-cycle memory latency.
    do_reset();
    imem_in.mem_valid = 1'b1;
    imem_in.mem_instr = 1'b1;
    imem_in.mem_addr  = 32'h100;
    #1;
    chk("t1_sample_valid", 32'(mem_in.mem_valid), 32'd0);
    serve("t1", 1'b0, 32'h100, 1'b0, 1, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // Memory ready while IDLE must not reach either port.
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h12345678;
    #1;
    chk("idle_ready_i", 32'(imem_out.mem_ready), 32'd0);
    chk("idle_ready_d", 32'(dmem_out.mem_ready), 32'd0);
    chk("idle_rdata_i", imem_out.mem_rdata, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_ready_novalid", 32'(mem_in.mem_valid), 32'd0);
    mem_out = '0;

    // Simultaneous first requests: instruction wins, then data.
    do_reset();
    imem_in.mem_valid = 1'b1;
    imem_in.mem_instr = 1'b1;
    imem_in.mem_addr  = 32'h0;
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h80;
    serve("t2_i", 1'b0, 32'h0, 1'b0, 1, 1, 32'h11111111, 1'b0, 1'b0);
    serve("t2_d", 1'b1, 32'h80, 1'b0, 1, 2, 32'h22222222, 1'b0, 1'b0);

    // Burst cap of 4: I,I,I,I,D,I,I,I.
    do_reset();
    order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    iaddr = 32'h0;
    imem_in.mem_valid = 1'b1;
    imem_in.mem_instr = 1'b1;
    imem_in.mem_addr  = iaddr;
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h200;
    for (int k = 0; k < 8; k++) begin
      if (order[k]) begin
        serve($sformatf("t3_b%0d", k), 1'b1, 32'h200, 1'b0, 1, 1, 32'hD0000000 + 32'(k),
              1'b0, 1'b0);
      end else begin
        serve($sformatf("t3_b%0d", k), 1'b0, iaddr, 1'b0, 1, 1, 32'hA0000000 + 32'(k),
              k != 7, 1'b0);
        iaddr = iaddr + 32'd4;
        imem_in.mem_addr = iaddr;
      end
    end

    // Request fields stay latched while the requester changes them.
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h40;
    serve("t4_latch", 1'b1, 32'h40, 1'b0, 1, 3, 32'h44444444, 1'b0, 1'b1);

    // Fence is forwarded and acknowledged like any request.
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_fence = 1'b1;
    dmem_in.mem_addr  = 32'h300;
    serve("t4_fence", 1'b1, 32'h300, 1'b1, 1, 2, 32'h0F0F0F0F, 1'b0, 1'b0);
    dmem_in.mem_fence = 1'b0;

    // Asynchronous reset during BUSY, followed by a late memory ready.
    imem_in.mem_valid = 1'b1;
    imem_in.mem_instr = 1'b1;
    imem_in.mem_addr  = 32'h500;
    @(negedge clk);
    #1;
    chk("t5_busy_valid", 32'(mem_in.mem_valid), 32'd1);
    rst = 1'b1;
    imem_in.mem_valid = 1'b0;
    #1;
    chk("t5_async_drop", 32'(mem_in.mem_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h55555555;
    #1;
    chk("t5_late_i_ready", 32'(imem_out.mem_ready), 32'd0);
    chk("t5_late_d_ready", 32'(dmem_out.mem_ready), 32'd0);
    chk("t5_late_valid", 32'(mem_in.mem_valid), 32'd0);
    @(negedge clk);
    mem_out = '0;
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = 32'h504;
    serve("t5_next", 1'b0, 32'h504, 1'b0, 1, 1, 32'h50450450, 1'b0, 1'b0);

    // Owner drops valid while BUSY; pending instruction request follows.
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h600;
    @(negedge clk);
    #1;
    dmem_in.mem_valid = 1'b0;
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = 32'h700;
    serve("t6_drop", 1'b1, 32'h600, 1'b0, 0, 2, 32'h66666666, 1'b0, 1'b0);
    serve("t6_next", 1'b0, 32'h700, 1'b0, 1, 1, 32'h77777777, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
